// File: rtl/sphere_decoder_dfs_pkg.sv
// Shared definitions for the depth-first sphere decoder.
//   - sd_state_e    : search FSM states
//   - PSK LUTs      : QPSK / 8-PSK unit-circle points, 16 fractional bits
//   - sd_scale      : rounds a LUT value to the datapath fractional width
//   - sd_gray       : binary-to-Gray label conversion
//   - sd_cw_lsb     : LSB position of complex word idx in an N_ANT-word vector
package sd_pkg;

  typedef enum logic [2:0] {
    StLoadR,
    StWaitY,
    StEntry,
    StCompute,
    StCompare,
    StBacktrack,
    StDone,
    StOutput
  } sd_state_e;

  localparam int LutFrac = 16;

  // 46341 = round(cos(pi/4) * 2^16)
  localparam int Psk8Re [8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
  localparam int Psk8Im [8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};
  localparam int QpskRe [4] = '{65536, 0, -65536, 0};
  localparam int QpskIm [4] = '{0, 65536, 0, -65536};

  function automatic int sd_point_re(int k, int bps);
    return (bps == 2) ? QpskRe[k & 3] : Psk8Re[k & 7];
  endfunction

  function automatic int sd_point_im(int k, int bps);
    return (bps == 2) ? QpskIm[k & 3] : Psk8Im[k & 7];
  endfunction

  // Round-half-up so that +/-cos(pi/4) scale to symmetric magnitudes.
  function automatic int sd_scale(int v, int frac);
    if (frac >= LutFrac) begin
      return v <<< (frac - LutFrac);
    end
    return (v + (1 <<< (LutFrac - frac - 1))) >>> (LutFrac - frac);
  endfunction

  function automatic logic [3:0] sd_gray(logic [3:0] idx);
    return idx ^ (idx >> 1);
  endfunction

  // Element 0 sits in the MSBs; each element is {re, im}.
  function automatic int sd_cw_lsb(int idx, int n_ant, int width);
    return (n_ant - 1 - idx) * 2 * width;
  endfunction

endpackage

// File: rtl/sphere_decoder_dfs_ped.sv
// sd_ped_unit: partial Euclidean distance |y_a - sum_{j>=a} R[a][j]*s_j|^2.
// Stage 1 registers the full-precision complex residual (truncated back to
// FRAC_W fractional bits); the squared magnitude is then delayed so that
// valid_o rises exactly PED_LAT cycles after start_i. Saturates at DIST_W.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : capture inputs and launch one PED
//   ant_i         : antenna index a (row of R, first used column)
//   y_i           : received component y_a {re, im}
//   row_i         : row a of R, element 0 in MSBs
//   sym_i         : current symbol coordinates, element 0 in MSBs
//   valid_o/ped_o : result strobe and distance
module sd_ped_unit #(
  parameter int unsigned N_ANT   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned DIST_W  = 36,
  parameter int unsigned PED_LAT = 3,
  localparam int unsigned AW     = $clog2(N_ANT)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [AW-1:0]              ant_i,
  input  logic [2*WIDTH-1:0]         y_i,
  input  logic [2*WIDTH*N_ANT-1:0]   row_i,
  input  logic [2*WIDTH*N_ANT-1:0]   sym_i,
  output logic                       valid_o,
  output logic [DIST_W-1:0]          ped_o
);
  import sd_pkg::*;

  localparam int unsigned AccW = 2 * WIDTH + $clog2(N_ANT + 1) + 2;
  localparam int unsigned SqW  = 2 * AccW;

  logic signed [AccW-1:0] acc_re, acc_im, rr, ri, sr, si;
  logic signed [AccW-1:0] res_re_q, res_im_q;
  logic signed [SqW-1:0]  sq_re, sq_im, sq;
  logic                   v1_q;
  logic [DIST_W-1:0]      ped_sat;

  always_comb begin
    acc_re = AccW'(signed'(y_i[WIDTH +: WIDTH])) <<< FRAC_W;
    acc_im = AccW'(signed'(y_i[0 +: WIDTH])) <<< FRAC_W;
    rr = '0;
    ri = '0;
    sr = '0;
    si = '0;
    for (int j = 0; j < N_ANT; j++) begin
      if (j >= int'(ant_i)) begin
        rr = AccW'(signed'(row_i[sd_cw_lsb(j, N_ANT, WIDTH) + WIDTH +: WIDTH]));
        ri = AccW'(signed'(row_i[sd_cw_lsb(j, N_ANT, WIDTH) +: WIDTH]));
        sr = AccW'(signed'(sym_i[sd_cw_lsb(j, N_ANT, WIDTH) + WIDTH +: WIDTH]));
        si = AccW'(signed'(sym_i[sd_cw_lsb(j, N_ANT, WIDTH) +: WIDTH]));
        acc_re = acc_re - (rr * sr - ri * si);
        acc_im = acc_im - (rr * si + ri * sr);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      v1_q <= start_i;
      if (start_i) begin
        res_re_q <= acc_re >>> FRAC_W;
        res_im_q <= acc_im >>> FRAC_W;
      end
    end
  end

  always_comb begin
    sq_re = SqW'(res_re_q);
    sq_im = SqW'(res_im_q);
    sq    = sq_re * sq_re + sq_im * sq_im;
    ped_sat = (|sq[SqW-1:DIST_W]) ? '1 : sq[DIST_W-1:0];
  end

  if (PED_LAT == 1) begin : g_lat1
    assign valid_o = v1_q;
    assign ped_o   = ped_sat;
  end else begin : g_latn
    logic [DIST_W-1:0]  dly_q [PED_LAT-1];
    logic [PED_LAT-2:0] vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < PED_LAT - 1; i++) dly_q[i] <= '0;
      end else begin
        vld_q[0] <= v1_q;
        dly_q[0] <= ped_sat;
        for (int i = 1; i < PED_LAT - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign valid_o = vld_q[PED_LAT-2];
    assign ped_o   = dly_q[PED_LAT-2];
  end

endmodule

// File: rtl/sphere_decoder_dfs.sv
// Depth-first sphere decoder, N_ANT x N_ANT, QPSK (BPS=2) or 8-PSK (BPS=3).
// Loads upper-triangular R row by row, then decodes each y vector with a DFS
// and radius pruning; the result leaves through a valid/ready handshake.
// Optional macro SD_NODE_BUDGET_EN adds MAX_NODES: once that many COMPARE
// steps have run and a leaf exists, the search stops early (o_early=1).
// Ports:
//   Clk, Reset_n    : clock, async active-low reset
//   i_r_valid       : i_data carries one R row
//   i_y_valid       : i_data carries a y vector
//   i_data          : N_ANT complex words {re,im}, element 0 in MSBs
//   o_in_ready      : inputs are taken this cycle
//   o_valid/i_out_ready : decision handshake
//   o_data          : Gray symbol labels, antenna 0 in MSBs
//   o_dist          : metric of the decision
//   o_early         : decision came from budget termination
module sphere_decoder_dfs
  import sd_pkg::*;
#(
  parameter int unsigned N_ANT   = 4,
  parameter int unsigned BPS     = 3,
  parameter int unsigned INT_W   = 6,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned WIDTH   = INT_W + FRAC_W,
  parameter int unsigned PED_LAT = 3,
  parameter int unsigned DIST_W  = 2 * WIDTH + 4
`ifdef SD_NODE_BUDGET_EN
  , parameter int unsigned MAX_NODES = 64
`endif
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     i_r_valid,
  input  logic                     i_y_valid,
  input  logic [2*WIDTH*N_ANT-1:0] i_data,
  output logic                     o_in_ready,
  output logic                     o_valid,
  input  logic                     i_out_ready,
  output logic [BPS*N_ANT-1:0]     o_data,
  output logic [DIST_W-1:0]        o_dist,
  output logic                     o_early
);

  localparam int unsigned CW     = 2 * WIDTH;
  localparam int unsigned VW     = CW * N_ANT;
  localparam int unsigned AW     = $clog2(N_ANT);
  localparam int unsigned CntW   = BPS + 1;
  localparam int unsigned NumSym = 1 << BPS;

  sd_state_e         state_q, state_d;
  logic              rdy_en_q;
  logic [AW-1:0]     rc_q, rc_d;
  logic [AW-1:0]     lvl_q, lvl_d, lvl_m1, lvl_p1, ant;
  logic [VW-1:0]     r_q [N_ANT];
  logic [VW-1:0]     r_d [N_ANT];
  logic [VW-1:0]     y_q, y_d;
  logic [DIST_W-1:0] best_q, best_d;
  logic [BPS-1:0]    cand_q [N_ANT];
  logic [BPS-1:0]    cand_d [N_ANT];
  logic [BPS-1:0]    sym_q [N_ANT];
  logic [BPS-1:0]    sym_d [N_ANT];
  logic [CntW-1:0]   c_q [N_ANT];
  logic [CntW-1:0]   c_d [N_ANT];
  logic [DIST_W-1:0] d_q [N_ANT];
  logic [DIST_W-1:0] d_d [N_ANT];
  logic [BPS*N_ANT-1:0] odata_q, odata_d;
  logic [DIST_W-1:0] odist_q, odist_d;

  logic              ped_start, ped_valid;
  logic [DIST_W-1:0] ped, dprev, acc_sat;
  logic [DIST_W:0]   acc_sum;
  logic [VW-1:0]     sym_vec;
  logic [CW-1:0]     y_a;
  logic [BPS-1:0]    idx;
  logic [3:0]        gray;
  int                pt;

`ifdef SD_NODE_BUDGET_EN
  localparam int unsigned NodeW = $clog2(MAX_NODES + 1);
  logic [NodeW-1:0] nodes_q, nodes_d;
  logic             leaf_q, leaf_d, early_q, early_d, oearly_q, oearly_d;
  assign o_early = oearly_q;
`else
  assign o_early = 1'b0;
`endif

  assign lvl_m1     = lvl_q - 1'b1;
  assign lvl_p1     = lvl_q + 1'b1;
  assign ant        = AW'(N_ANT - 1) - lvl_q;
  assign o_in_ready = rdy_en_q & ((state_q == StLoadR) | (state_q == StWaitY));
  assign o_valid    = (state_q == StOutput);
  assign o_data     = odata_q;
  assign o_dist     = odist_q;

  // Symbol coordinates for the PED: the antenna under test takes the child
  // being entered, all deeper-in-tree antennas keep their path symbol.
  always_comb begin
    sym_vec = '0;
    pt      = 0;
    idx     = '0;
    for (int j = 0; j < N_ANT; j++) begin
      idx = (AW'(j) == ant) ? c_q[lvl_q][BPS-1:0] : sym_q[j];
      pt  = sd_scale(sd_point_re(int'(idx), int'(BPS)), int'(FRAC_W));
      sym_vec[sd_cw_lsb(j, N_ANT, WIDTH) + WIDTH +: WIDTH] = pt[WIDTH-1:0];
      pt  = sd_scale(sd_point_im(int'(idx), int'(BPS)), int'(FRAC_W));
      sym_vec[sd_cw_lsb(j, N_ANT, WIDTH) +: WIDTH] = pt[WIDTH-1:0];
    end
    y_a = y_q[sd_cw_lsb(int'(ant), N_ANT, WIDTH) +: CW];
  end

  sd_ped_unit #(
    .N_ANT   (N_ANT),
    .WIDTH   (WIDTH),
    .FRAC_W  (FRAC_W),
    .DIST_W  (DIST_W),
    .PED_LAT (PED_LAT)
  ) u_ped (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .start_i (ped_start),
    .ant_i   (ant),
    .y_i     (y_a),
    .row_i   (r_q[ant]),
    .sym_i   (sym_vec),
    .valid_o (ped_valid),
    .ped_o   (ped)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    r_d     = r_q;
    y_d     = y_q;
    best_d  = best_q;
    cand_d  = cand_q;
    sym_d   = sym_q;
    c_d     = c_q;
    d_d     = d_q;
    lvl_d   = lvl_q;
    odata_d = odata_q;
    odist_d = odist_q;
    ped_start = 1'b0;
    gray    = '0;
`ifdef SD_NODE_BUDGET_EN
    nodes_d  = nodes_q;
    leaf_d   = leaf_q;
    early_d  = early_q;
    oearly_d = oearly_q;
`endif
    dprev   = (lvl_q == '0) ? '0 : d_q[lvl_m1];
    acc_sum = {1'b0, dprev} + {1'b0, ped};
    acc_sat = acc_sum[DIST_W] ? '1 : acc_sum[DIST_W-1:0];

    unique case (state_q)
      StLoadR: begin
        if (i_r_valid && rdy_en_q) begin
          r_d[rc_q] = i_data;
          if (rc_q == AW'(N_ANT - 1)) begin
            rc_d    = '0;
            state_d = StWaitY;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      StWaitY: begin
        if (i_r_valid) begin
          r_d[0]  = i_data;
          rc_d    = AW'(1);
          state_d = StLoadR;
        end else if (i_y_valid) begin
          y_d    = i_data;
          best_d = '1;
          for (int i = 0; i < N_ANT; i++) c_d[i] = '0;
          lvl_d  = '0;
`ifdef SD_NODE_BUDGET_EN
          nodes_d = '0;
          leaf_d  = 1'b0;
          early_d = 1'b0;
`endif
          state_d = StEntry;
        end
      end
      StEntry: begin
`ifdef SD_NODE_BUDGET_EN
        if (leaf_q && (nodes_q == NodeW'(MAX_NODES))) begin
          early_d = 1'b1;
          state_d = StDone;
        end else
`endif
        if (c_q[lvl_q] == CntW'(NumSym)) begin
          state_d = StBacktrack;
        end else begin
          sym_d[ant] = c_q[lvl_q][BPS-1:0];
          ped_start  = 1'b1;
          state_d    = StCompute;
        end
      end
      StCompute: begin
        if (ped_valid) begin
          d_d[lvl_q] = acc_sat;
          state_d    = StCompare;
        end
      end
      StCompare: begin
        c_d[lvl_q] = c_q[lvl_q] + 1'b1;
`ifdef SD_NODE_BUDGET_EN
        if (nodes_q != NodeW'(MAX_NODES)) nodes_d = nodes_q + 1'b1;
`endif
        state_d = StEntry;
        // Strict less-than: ties keep the first leaf found.
        if (d_q[lvl_q] < best_q) begin
          if (lvl_q == AW'(N_ANT - 1)) begin
            best_d = d_q[lvl_q];
            cand_d = sym_q;
`ifdef SD_NODE_BUDGET_EN
            leaf_d = 1'b1;
`endif
          end else begin
            lvl_d       = lvl_p1;
            c_d[lvl_p1] = '0;
          end
        end
      end
      StBacktrack: begin
        if (lvl_q == '0) begin
          state_d = StDone;
        end else begin
          lvl_d   = lvl_m1;
          state_d = StEntry;
        end
      end
      StDone: begin
        for (int j = 0; j < N_ANT; j++) begin
          gray = sd_gray(4'(cand_q[j]));
          odata_d[(N_ANT - 1 - j) * BPS +: BPS] = gray[BPS-1:0];
        end
        odist_d = best_q;
`ifdef SD_NODE_BUDGET_EN
        oearly_d = early_q;
`endif
        state_d = StOutput;
      end
      StOutput: begin
        if (i_out_ready) state_d = StWaitY;
      end
      default: state_d = StLoadR;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StLoadR;
      rdy_en_q <= 1'b0;
      rc_q     <= '0;
      lvl_q    <= '0;
      y_q      <= '0;
      best_q   <= '0;
      odata_q  <= '0;
      odist_q  <= '0;
      for (int i = 0; i < N_ANT; i++) begin
        r_q[i]    <= '0;
        cand_q[i] <= '0;
        sym_q[i]  <= '0;
        c_q[i]    <= '0;
        d_q[i]    <= '0;
      end
`ifdef SD_NODE_BUDGET_EN
      nodes_q  <= '0;
      leaf_q   <= 1'b0;
      early_q  <= 1'b0;
      oearly_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      rc_q     <= rc_d;
      lvl_q    <= lvl_d;
      y_q      <= y_d;
      best_q   <= best_d;
      odata_q  <= odata_d;
      odist_q  <= odist_d;
      r_q      <= r_d;
      cand_q   <= cand_d;
      sym_q    <= sym_d;
      c_q      <= c_d;
      d_q      <= d_d;
`ifdef SD_NODE_BUDGET_EN
      nodes_q  <= nodes_d;
      leaf_q   <= leaf_d;
      early_q  <= early_d;
      oearly_q <= oearly_d;
`endif
    end
  end

endmodule

// File: doc/sphere_decoder_dfs.md
Name: sphere_decoder_dfs

Overview:
Parametrised depth-first sphere decoder for an N_ANT x N_ANT MIMO link with QPSK/8-PSK symbols. It takes the upper-triangular channel matrix R row by row, then one received vector y, and runs a DFS with radius pruning over the symbol tree. It returns the Gray-coded minimum-distance symbol vector through a valid/ready output handshake. It generalises the fixed 4x4 8-PSK detector: antenna count, modulation, widths and PED pipeline depth are parameters; R reload, output back-pressure and distance saturation are added.

Parameters:
N_ANT, 4, antennas = tree depth (2..8)
BPS, 3, bits per symbol; 2 = QPSK, 3 = 8-PSK (other values illegal)
INT_W, 6, integer bits incl. sign of each real/imag component
FRAC_W, 10, fractional bits
WIDTH, INT_W+FRAC_W, component width
PED_LAT, 3, latency of sd_ped_unit in cycles (>=1)
DIST_W, 2*WIDTH+4, unsigned accumulated-distance width

Ports:
Clk  in  1  clock
Reset_n  in  1  asynchronous active-low reset
i_r_valid  in  1  R row present on i_data
i_y_valid  in  1  y vector present on i_data
i_data  in  2*WIDTH*N_ANT  N_ANT complex words {re,im}; element 0 in MSBs
o_in_ready  out  1  block accepts i_r_valid / i_y_valid this cycle
o_valid  out  1  decision valid
i_out_ready  in  1  sink accepts decision
o_data  out  BPS*N_ANT  Gray symbol labels; antenna 0 in MSBs
o_dist  out  DIST_W  metric of the decision
o_early  out  1  decision from budget termination (0 when macro absent)

Behaviour:
- Reset (any time, incl. mid-search): state LOAD_R, row counter 0, R marked invalid. o_valid=0, o_data=0, o_dist=0, o_early=0, o_in_ready=0 until the first cycle after reset release.
- States: LOAD_R -> WAIT_Y -> ENTRY -> COMPUTE -> COMPARE -> (ENTRY | BACKTRACK) -> DONE -> OUTPUT -> WAIT_Y.
- LOAD_R: o_in_ready=1. Each cycle with i_r_valid stores i_data as row rc and increments rc. After row N_ANT-1 go to WAIT_Y. i_y_valid is ignored here.
- WAIT_Y: o_in_ready=1. i_r_valid restarts the load: the row is stored as row 0, rc=1, state LOAD_R. i_y_valid latches y, sets best radius to all-ones (DIST_W), clears all child counters, sets level 0, and goes to ENTRY. If both valids are high, R wins.
- o_in_ready=0 in all other states. Inputs presented there are dropped.
- Level l searches antenna a=N_ANT-1-l. Its child counter c[l] runs 0..2^BPS.
  - ENTRY with c[l]==2^BPS: go to BACKTRACK.
  - Otherwise: s_a = LUT[c[l]], start sd_ped_unit, go to COMPUTE.
- sd_ped_unit returns |y_a - sum_{j>=a} R[a][j]*s_j|^2 exactly PED_LAT cycles after start. COMPUTE waits for its valid.
- Accumulation: d[l] = d[l-1] + ped, with d[-1]=0. The sum saturates at 2^DIST_W-1.
- COMPARE: c[l]++.
  - If d[l] >= best: pruned, go to ENTRY at the same level.
  - Else if l==N_ANT-1: best=d[l], candidate=current c vector, go to ENTRY.
  - Else: go deeper, l++, c[l]=0, then ENTRY.
  - Ties never replace the incumbent: the first-found leaf wins.
- BACKTRACK: l==0 goes to DONE; else l--, then ENTRY.
- DONE: o_data = Gray(candidate index), per antenna idx^(idx>>1); o_dist=best. Next cycle is OUTPUT.
- OUTPUT: o_valid=1. o_data and o_dist hold stable until i_out_ready. In the cycle of the handshake, o_valid drops and the state goes to WAIT_Y. R is retained for later y vectors.
- Constellation: point k = (cos 2*pi*k/2^BPS, sin 2*pi*k/2^BPS) in Q(INT_W.FRAC_W). 8-PSK k=0 is (1.0,0) = 0x0400/0x0000.
- Products are full precision; the PED is rounded to DIST_W by truncating 2*FRAC_W-FRAC_W fractional bits.

Optional Feature:
SD_NODE_BUDGET_EN: adds parameter MAX_NODES (default 64), which counts COMPARE events per vector.
- When the count reaches MAX_NODES and a leaf has already been accepted, the next ENTRY goes directly to DONE and o_early=1 for that decision.
- If no leaf has been accepted yet, the search continues to the first accepted leaf, then terminates.
- Without the macro: no counter, exhaustive search, o_early tied 0.

Decomposition:
- Package sd_pkg holds:
  - state enum;
  - QPSK and 8-PSK constellation LUT constants;
  - the Gray-encode function;
  - the complex-word slice helpers.
- One sub-module, sd_ped_unit: a pipelined complex multiply-accumulate plus magnitude-squared with a valid in/out, latency PED_LAT.

Test Plan:
- R=identity (0x0400 diagonal), y = 8-PSK points [4,2,0,6] -> o_data = Gray {6,3,0,5} = 12'b110_011_000_101, o_dist=0, o_early=0.
- Same vector with i_out_ready held low 20 cycles -> o_valid and o_data stable for the whole interval; o_in_ready=0; a y pulse in that window is ignored.
- Two y vectors sent back-to-back after one R load -> both decisions correct; no R reload needed.
- In WAIT_Y, i_r_valid and i_y_valid high together -> R load restarts (rc=1); no search starts.
- Reset_n pulsed low mid-COMPUTE -> o_valid=0 immediately; the block returns to LOAD_R; a full reload then decodes correctly.
- With SD_NODE_BUDGET_EN and MAX_NODES=N_ANT, random y -> o_early=1; o_dist equals the metric of the first leaf found.
